// File: rtl/i2s_tx_serializer.sv
// ----------------------------------------------------------------------------
// i2s_tx_serializer
//
// Takes the mono sample stream of the BRAM sample player and sends it out as a
// Philips I2S stream. The same sample goes into the left and right slots. The
// bit clock and word select are derived from mclk. The block counts frames
// that had no fresh sample (underrun) and samples that were overwritten
// before they were sent (overrun).
//
// Ports
//   mclk          audio master clock, sole clock
//   rst           asynchronous reset, active low
//   enable        0: serializer idles with outputs low, 1: frames run
//   sample_in     signed sample, captured when sample_valid=1
//   sample_valid  single-cycle capture strobe
//   bclk          I2S bit clock
//   lrclk         word select (0 = left, 1 = right)
//   sdata         serial data, MSB first, changes with the falling edge of bclk
//   frame_start   one-mclk pulse when holding is moved into the frame register
//   underrun_cnt  saturating count of frames sent without a fresh sample
//   overrun_cnt   saturating count of samples overwritten before being sent
//
// States
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | not yet started; the next bclk fall begins a frame (bit 0)
//   ST_RUN  | frames running; each bclk fall advances the bit counter
// ----------------------------------------------------------------------------
module i2s_tx_serializer #(
    parameter int MCLK_PER_BCLK = 8,
    parameter int SAMPLE_BITS   = 16,
    parameter int SLOT_BITS     = 16,
    parameter int CNT_BITS      = 8
) (
    input  logic                   mclk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [SAMPLE_BITS-1:0] sample_in,
    input  logic                   sample_valid,
    output logic                   bclk,
    output logic                   lrclk,
    output logic                   sdata,
    output logic                   frame_start,
    output logic [CNT_BITS-1:0]    underrun_cnt,
    output logic [CNT_BITS-1:0]    overrun_cnt
);

    localparam int DW = $clog2(MCLK_PER_BCLK);
    localparam int BW = $clog2(2 * SLOT_BITS);
    localparam int SW = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;

    localparam logic [DW-1:0]       DCNT_LAST = DW'(MCLK_PER_BCLK - 1);
    localparam logic [DW-1:0]       DCNT_HALF = DW'(MCLK_PER_BCLK / 2);
    localparam logic [BW-1:0]       BIT_LAST  = BW'(2 * SLOT_BITS - 1);
    localparam logic [BW-1:0]       SLOT_N    = BW'(SLOT_BITS);
    localparam logic [SW-1:0]       SLOT_LAST = SW'(SLOT_BITS - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX   = '1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 r_state;
    logic [DW-1:0]          r_dcnt;
    logic [BW-1:0]          r_bitcnt;
    logic [SAMPLE_BITS-1:0] r_hold;
    logic                   r_fresh;
    logic [SAMPLE_BITS-1:0] r_frame;
    logic                   r_bclk;
    logic                   r_lrclk;
    logic                   r_sdata;
    logic                   r_frame_start;
    logic [CNT_BITS-1:0]    r_under;
    logic [CNT_BITS-1:0]    r_over;

    logic [DW-1:0]          w_dcnt_next;
    logic                   w_fall;
    logic [BW-1:0]          w_bit_next;
    logic                   w_boundary;
    logic [BW-1:0]          w_pos;
    logic [SW-1:0]          w_sbit_idx;
    logic [SAMPLE_BITS-1:0] w_rev;
    logic [SLOT_BITS-1:0]   w_slot;
    logic                   w_sdata_next;

    always_comb begin
        w_dcnt_next = (r_dcnt == DCNT_LAST) ? '0 : r_dcnt + 1'b1;
        w_fall      = enable && (r_dcnt == DCNT_LAST);

        // The first fall after idle starts a frame rather than advancing.
        if (r_state == ST_IDLE || r_bitcnt == BIT_LAST) begin
            w_bit_next = '0;
        end else begin
            w_bit_next = r_bitcnt + 1'b1;
        end
        w_boundary = w_fall && (w_bit_next == '0);

        // One-bit I2S delay: slot position p carries slot bit p-1; position 0
        // carries the last bit of the slot before it. The frame register is
        // only reloaded at the same edge, so position 0 of the left slot still
        // reads the previous frame's last bit.
        w_pos      = (w_bit_next >= SLOT_N) ? w_bit_next - SLOT_N : w_bit_next;
        w_sbit_idx = (w_pos == '0) ? SLOT_LAST : SW'(w_pos - 1'b1);

        // Slot bit i is sample bit MSB-i; padding LSBs of the slot are zero.
        w_rev = '0;
        for (int i = 0; i < SAMPLE_BITS; i++) begin
            w_rev[i] = r_frame[SAMPLE_BITS-1-i];
        end
        w_slot       = SLOT_BITS'(w_rev);
        w_sdata_next = w_slot[w_sbit_idx];
    end

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_dcnt        <= '0;
            r_bitcnt      <= '0;
            r_hold        <= '0;
            r_fresh       <= 1'b0;
            r_frame       <= '0;
            r_bclk        <= 1'b0;
            r_lrclk       <= 1'b0;
            r_sdata       <= 1'b0;
            r_frame_start <= 1'b0;
            r_under       <= '0;
            r_over        <= '0;
        end else begin
            r_frame_start <= 1'b0;

            if (!enable) begin
                r_state  <= ST_IDLE;
                r_dcnt   <= '0;
                r_bitcnt <= '0;
                r_bclk   <= 1'b0;
                r_lrclk  <= 1'b0;
                r_sdata  <= 1'b0;
            end else begin
                r_dcnt <= w_dcnt_next;
                r_bclk <= (w_dcnt_next >= DCNT_HALF);
                if (w_fall) begin
                    r_state  <= ST_RUN;
                    r_bitcnt <= w_bit_next;
                    r_lrclk  <= (w_bit_next >= SLOT_N);
                    r_sdata  <= w_sdata_next;
                end
            end

            if (w_boundary) begin
                r_frame       <= r_hold;
                r_frame_start <= 1'b1;
                if (!r_fresh && r_under != CNT_MAX) begin
                    r_under <= r_under + 1'b1;
                end
            end

            // A strobe coinciding with a boundary is not an overrun: the old
            // holding value has just been handed to the frame register.
            if (sample_valid) begin
                r_hold  <= sample_in;
                r_fresh <= 1'b1;
                if (r_fresh && !w_boundary && r_over != CNT_MAX) begin
                    r_over <= r_over + 1'b1;
                end
            end else if (w_boundary) begin
                r_fresh <= 1'b0;
            end
        end
    end

    assign bclk         = r_bclk;
    assign lrclk        = r_lrclk;
    assign sdata        = r_sdata;
    assign frame_start  = r_frame_start;
    assign underrun_cnt = r_under;
    assign overrun_cnt  = r_over;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
module tb_i2s_tx_serializer;

    logic        mclk = 1'b0;
    logic        rst;
    logic        enable;
    logic        en24;
    logic        sample_valid;
    logic [15:0] sample_in;

    logic       bclk0, lr0, sd0, fs0;
    logic [7:0] ur0, or0;
    logic       bclk2, lr2, sd2, fs2;
    logic [1:0] ur2, or2;
    logic       bclk24, lr24, sd24, fs24;
    logic [7:0] ur24, or24;

    int n_tests = 0;
    int n_fail  = 0;
    int w;

    logic bits_h [0:48];
    logic lr_h   [0:48];
    logic bclk_h [0:384];
    logic fs_h   [0:384];

    always #5 mclk = ~mclk;

    i2s_tx_serializer dut0 (
        .mclk(mclk), .rst(rst), .enable(enable), .sample_in(sample_in),
        .sample_valid(sample_valid), .bclk(bclk0), .lrclk(lr0), .sdata(sd0),
        .frame_start(fs0), .underrun_cnt(ur0), .overrun_cnt(or0)
    );

    i2s_tx_serializer #(.CNT_BITS(2)) dut2 (
        .mclk(mclk), .rst(rst), .enable(enable), .sample_in(sample_in),
        .sample_valid(sample_valid), .bclk(bclk2), .lrclk(lr2), .sdata(sd2),
        .frame_start(fs2), .underrun_cnt(ur2), .overrun_cnt(or2)
    );

    i2s_tx_serializer #(.SLOT_BITS(24)) dut24 (
        .mclk(mclk), .rst(rst), .enable(en24), .sample_in(sample_in),
        .sample_valid(sample_valid), .bclk(bclk24), .lrclk(lr24), .sdata(sd24),
        .frame_start(fs24), .underrun_cnt(ur24), .overrun_cnt(or24)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic strobe(input logic [15:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    function automatic logic cur_fs(input int sel);
        return (sel == 0) ? fs0 : fs24;
    endfunction

    function automatic logic cur_sd(input int sel);
        return (sel == 0) ? sd0 : sd24;
    endfunction

    function automatic logic cur_lr(input int sel);
        return (sel == 0) ? lr0 : lr24;
    endfunction

    function automatic logic cur_bclk(input int sel);
        return (sel == 0) ? bclk0 : bclk24;
    endfunction

    task automatic wait_fs(input int sel, input int max, output int waited);
        waited = 0;
        while (cur_fs(sel) !== 1'b1 && waited < max) begin
            tick();
            waited++;
        end
        check("fs_timeout", {31'd0, cur_fs(sel)}, 32'd1);
    endtask

    task automatic next_frame();
        int dummy;
        tick();
        wait_fs(0, 300, dummy);
    endtask

    // Must be entered one step after a frame_start edge; leaves one step after
    // the next frame_start edge. Records sdata/lrclk at every bit position
    // (including the following frame's position 0) and bclk/frame_start per mclk.
    task automatic capture(input int sel);
        int nb;
        nb = (sel == 0) ? 32 : 48;
        for (int c = 0; c <= 8 * nb; c++) begin
            if (c > 0) tick();
            bclk_h[c] = cur_bclk(sel);
            fs_h[c]   = cur_fs(sel);
            if (c % 8 == 0) begin
                bits_h[c/8] = cur_sd(sel);
                lr_h[c/8]   = cur_lr(sel);
            end
        end
    endtask

    function automatic logic [15:0] word_at(input int start);
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[15-i] = bits_h[start+i];
        return v;
    endfunction

    function automatic logic [7:0] byte_at(input int start);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[7-i] = bits_h[start+i];
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b0;
        enable       = 1'b1;
        en24         = 1'b0;
        sample_valid = 1'b0;
        sample_in    = 16'h0000;
        repeat (3) tick();

        // Reset state
        check("rst_outs0", {28'd0, bclk0, lr0, sd0, fs0}, 32'd0);
        check("rst_cnts0", {16'd0, ur0, or0}, 32'd0);
        check("rst_dut2", {24'd0, bclk2, lr2, sd2, fs2, ur2, or2}, 32'd0);
        check("rst_dut24", {12'd0, bclk24, lr24, sd24, fs24, ur24, or24}, 32'd0);

        // Frame 1 with 16'h8001 offered before the first boundary
        rst = 1'b1;
        strobe(16'h8001);
        wait_fs(0, 20, w);
        check("first_boundary_delay", w, 7);
        check("f1_underrun", {24'd0, ur0}, 32'd0);
        check("f1_overrun", {24'd0, or0}, 32'd0);
        capture(0);
        check("f1_words", {word_at(1), word_at(17)}, 32'h8001_8001);
        check("bclk_shape", {27'd0, bclk_h[0], bclk_h[3], bclk_h[4], bclk_h[7], bclk_h[8]}, 32'b00110);
        check("lrclk_edges", {28'd0, lr_h[15], lr_h[16], lr_h[31], lr_h[32]}, 32'b0110);
        check("fs_period", {29'd0, fs_h[1], fs_h[255], fs_h[256]}, 32'b001);

        // Idle frames repeat the last sample
        check("f2_underrun", {24'd0, ur0}, 32'd1);
        capture(0);
        check("f2_words", {word_at(1), word_at(17)}, 32'h8001_8001);
        capture(0);
        check("f3_words", {word_at(1), word_at(17)}, 32'h8001_8001);
        check("underrun_3", {24'd0, ur0}, 32'd3);
        check("underrun_3_cnt2", {30'd0, ur2}, 32'd3);
        next_frame();
        next_frame();
        check("underrun_5", {24'd0, ur0}, 32'd5);
        check("underrun_sat_cnt2", {30'd0, ur2}, 32'd3);

        // Two strobes within one frame
        check("pre_overrun", {24'd0, or0}, 32'd0);
        repeat (20) tick();
        strobe(16'h1234);
        repeat (20) tick();
        strobe(16'h5678);
        check("overrun_1", {24'd0, or0}, 32'd1);
        next_frame();
        check("f7_underrun", {24'd0, ur0}, 32'd5);
        capture(0);
        check("f7_words", {word_at(1), word_at(17)}, 32'h5678_5678);
        check("f8_underrun", {24'd0, ur0}, 32'd6);

        // Strobe landing on the boundary edge
        repeat (10) tick();
        strobe(16'hA5A5);
        repeat (244) tick();
        strobe(16'h3C3C);
        check("coincident_fs", {31'd0, fs0}, 32'd1);
        check("coincident_overrun", {24'd0, or0}, 32'd1);
        check("coincident_underrun", {24'd0, ur0}, 32'd6);
        capture(0);
        check("f9_words", {word_at(1), word_at(17)}, 32'hA5A5_A5A5);
        check("f10_underrun", {24'd0, ur0}, 32'd6);
        capture(0);
        check("f10_words", {word_at(1), word_at(17)}, 32'h3C3C_3C3C);
        check("f11_underrun", {24'd0, ur0}, 32'd7);

        // Reset in the middle of the right slot
        repeat (200) tick();
        check("mid_right_lrclk", {31'd0, lr0}, 32'd1);
        rst = 1'b0;
        #1;
        check("async_rst_outs", {28'd0, bclk0, lr0, sd0, fs0}, 32'd0);
        check("async_rst_cnts", {16'd0, ur0, or0}, 32'd0);
        repeat (3) tick();
        rst = 1'b1;
        wait_fs(0, 20, w);
        check("post_rst_boundary_delay", w, 8);
        check("post_rst_underrun", {24'd0, ur0}, 32'd1);
        capture(0);
        check("post_rst_words", {word_at(1), word_at(17)}, 32'h0000_0000);
        check("post_rst_f2_underrun", {24'd0, ur0}, 32'd2);

        // enable low for 20 mclk with a capture during the gap
        repeat (150) tick();
        check("pre_disable_lrclk", {31'd0, lr0}, 32'd1);
        enable = 1'b0;
        tick();
        check("disable_outs", {29'd0, bclk0, lr0, sd0}, 32'd0);
        strobe(16'hC003);
        repeat (18) tick();
        check("disable_outs_hold", {29'd0, bclk0, lr0, sd0}, 32'd0);
        check("disable_cnts_kept", {16'd0, ur0, or0}, {16'd0, 8'd2, 8'd0});
        enable = 1'b1;
        repeat (7) tick();
        check("reenable_fs_early", {31'd0, fs0}, 32'd0);
        tick();
        check("reenable_fs_at_8", {31'd0, fs0}, 32'd1);
        check("reenable_underrun", {24'd0, ur0}, 32'd2);
        capture(0);
        check("reenable_words", {word_at(1), word_at(17)}, 32'hC003_C003);

        // 24-bit slots carrying a 16-bit sample
        strobe(16'hFFFF);
        en24 = 1'b1;
        wait_fs(1, 20, w);
        check("s24_boundary_delay", w, 8);
        capture(1);
        check("s24_left_msbs", {16'd0, word_at(1)}, 32'h0000_FFFF);
        check("s24_left_pad", {24'd0, byte_at(17)}, 32'd0);
        check("s24_right_msbs", {16'd0, word_at(25)}, 32'h0000_FFFF);
        check("s24_right_pad", {24'd0, byte_at(41)}, 32'd0);
        check("s24_lrclk_edges", {28'd0, lr_h[23], lr_h[24], lr_h[47], lr_h[48]}, 32'b0110);
        check("s24_fs_period", {30'd0, fs_h[383], fs_h[384]}, 32'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
- Downstream consumer of the BRAM sample player's mono 16-bit output (current_sample plus its valid strobe).
- Generates the I2S bit clock and word-select from the master clock, and holds the most recent offered sample.
- Serializes that sample MSB-first, in Philips I2S format, onto both left and right slots of every frame.
- Flags underruns (no new sample for a frame) and overruns (sample overwritten before being sent).

Parameters:
- MCLK_PER_BCLK, 8, mclk cycles per bclk period; even, >=2.
- SAMPLE_BITS, 16, width of the sample.
- SLOT_BITS, 16, bclks per channel slot; >= SAMPLE_BITS; unused LSBs are sent as 0.
- CNT_BITS, 8, width of the saturating underrun and overrun counters.

Ports:
- mclk  in  1  sole clock, audio master clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  when 0, serializer idles; when 1, frames run continuously.
- sample_in  in  SAMPLE_BITS  signed sample, valid when sample_valid=1.
- sample_valid  in  1  single-cycle strobe; captures sample_in into the holding register.
- bclk  out  1  I2S bit clock.
- lrclk  out  1  word select; 0 = left, 1 = right.
- sdata  out  1  serial data, changes on bclk falling edge.
- frame_start  out  1  one-mclk pulse when the holding register is transferred to the frame register.
- underrun_cnt  out  CNT_BITS  saturating count of frames with no fresh sample.
- overrun_cnt  out  CNT_BITS  saturating count of samples overwritten before transmission.

Behaviour:
- Reset (rst=0, asynchronous) clears all counters and registers:
  - bclk=0, lrclk=0, sdata=0, frame_start=0, underrun_cnt=0, overrun_cnt=0.
  - Holding register=0, fresh flag=0.
- Divider dcnt runs 0..MCLK_PER_BCLK-1 while enable=1.
  - bclk=0 for dcnt < MCLK_PER_BCLK/2, else 1. All outputs are registered.
  - A "fall" event occurs when dcnt wraps to 0. All lrclk/sdata/bitcnt updates happen on a fall.
- Bit counter bitcnt runs 0..2*SLOT_BITS-1 and increments on each fall, wrapping to 0.
  - lrclk=0 for bitcnt < SLOT_BITS, else 1.
- I2S one-bit delay: sdata at slot position p (0..SLOT_BITS-1) carries slot bit p-1 of the same channel.
  - Slot bit i = sample bit [SAMPLE_BITS-1-i] for i < SAMPLE_BITS, else 0.
  - Position 0 of each slot carries the final slot bit of the previous slot (0 when SLOT_BITS > SAMPLE_BITS).
  - The frame register is the source for both slots.
- Frame boundary is the fall that sets bitcnt to 0.
  - Frame register <= holding register; frame_start=1 for that single mclk.
  - If fresh=0 at that point: the same sample repeats and underrun_cnt increments, saturating at all-ones.
  - fresh is then cleared.
- Capture: on sample_valid=1, holding <= sample_in and fresh <= 1.
  - If fresh was already 1 and no frame boundary occurs in the same cycle, overrun_cnt increments (saturating). Newest sample wins.
  - Simultaneous sample_valid and frame boundary: the frame register takes the old holding value; the new sample lands in holding with fresh=1; no overrun.
- Startup: the first frame after reset carries the holding value (0) and counts one underrun unless a sample arrived earlier.
- enable=0:
  - dcnt, bitcnt, bclk, lrclk and sdata are forced to 0 on the next mclk.
  - Holding register, fresh flag and counters are kept; sample capture continues.
- enable 0->1: the first fall occurs MCLK_PER_BCLK cycles later and is a frame boundary (bitcnt=0).
- Latency: a sample captured before a frame boundary has its MSB on sdata exactly one bclk after that boundary.
- Reset asserted mid-frame aborts the frame immediately, with no partial-word completion.

Test Plan:
- Defaults, enable=1, one sample 16'h8001 before the first boundary:
  - bclk period 8 mclk; lrclk period 256 mclk with 50% duty.
  - Left slot sdata at positions 1..16 = 1,0...0,1; right slot identical.
  - frame_start pulses every 256 mclk; underrun_cnt=0 after frame 1.
- No samples for 3 frames after the first:
  - Each frame repeats 16'h8001; underrun_cnt=3.
  - Saturation check: CNT_BITS=2 and 5 idle frames gives underrun_cnt=3.
- Two sample_valid strobes (16'h1234, then 16'h5678) within one frame:
  - overrun_cnt=1; next frame sends 16'h5678.
- sample_valid asserted in the same mclk as frame_start:
  - Current frame sends the prior holding value; the new value is sent next frame; overrun_cnt unchanged.
- SLOT_BITS=24, SAMPLE_BITS=16, sample 16'hFFFF:
  - Per slot, positions 1..16 are 1 and positions 17..23 plus next position 0 are 0; lrclk period 384 mclk.
- Assert rst low mid right slot, release, enable held 1:
  - All outputs 0 immediately.
  - First frame after release sends 0 and underrun_cnt=1.
  - enable toggled 0 for 20 mclk: bclk, lrclk and sdata stay 0, counters keep their values, and the next frame starts 8 mclk after re-enable.
